// File: rtl/regfile_writeback_ctrl_pkg.sv
// Shared constants and types for the register-bank writeback controller.
package regfile_writeback_ctrl_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } wb_src_e;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module wb_scoreboard
  import regfile_writeback_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              chk_en,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic              err
);
  localparam logic [NUM_REGS-1:0] X0_KEEP_OUT = {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                issue_err;
  logic                write_err;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && set_addr != ZERO_REG) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // A re-claim is only legal when the same register retires this cycle.
  assign issue_err = set_en && set_addr != ZERO_REG && pend[set_addr] && !clr_mask[set_addr];
  assign write_err = chk_en && chk_addr != ZERO_REG && !pend[chk_addr];

  assign rs1_busy = pend[rs1_addr];
  assign rs2_busy = pend[rs2_addr];
  assign rd_busy  = pend[set_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      err  <= 1'b0;
    end else begin
      // Set is applied after clear so a same-cycle set on the same register wins.
      pend <= ((pend & ~clr_mask) | set_mask) & X0_KEEP_OUT;
      err  <= err | issue_err | write_err;
    end
  end
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Merges ALU and load results onto the register bank's single write port.
// Load handshake: a load transfers on a cycle where wb_ld_valid && wb_ld_ready are both 1.
module regfile_writeback_ctrl
  import regfile_writeback_ctrl_pkg::*;
(
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic              wb_issue_en,
  input  logic [ADDR_W-1:0] wb_issue_rd,
  input  logic              wb_alu_valid,
  input  logic [ADDR_W-1:0] wb_alu_rd,
  input  logic [XLEN-1:0]   wb_alu_data,
  input  logic              wb_ld_valid,
  output logic              wb_ld_ready,
  input  logic [ADDR_W-1:0] wb_ld_rd,
  input  logic [XLEN-1:0]   wb_ld_data,
  input  logic [ADDR_W-1:0] wb_rs1_addr,
  input  logic [ADDR_W-1:0] wb_rs2_addr,
  output logic              wb_rs1_busy,
  output logic              wb_rs2_busy,
  output logic              wb_rd_busy,
  output logic              wb_reg_wr_en,
  output logic [ADDR_W-1:0] wb_reg_wr_addr,
  output logic [XLEN-1:0]   wb_reg_in,
  output logic              wb_err
);
  logic              ld_full;
  logic [ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              drain;
  logic              accept;
  wb_src_e           sel_src;
  logic [ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  // The buffered load leaves only on cycles the ALU is idle; a new load may refill it then.
  assign drain       = ld_full && !wb_alu_valid;
  assign wb_ld_ready = !ld_full || drain;
  assign accept      = wb_ld_valid && wb_ld_ready;

  always_comb begin
    sel_src  = SRC_NONE;
    sel_rd   = ZERO_REG;
    sel_data = '0;
    if (wb_alu_valid) begin
      sel_src  = SRC_ALU;
      sel_rd   = wb_alu_rd;
      sel_data = wb_alu_data;
    end else if (ld_full) begin
      sel_src  = SRC_LD;
      sel_rd   = ld_rd;
      sel_data = ld_data;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ld_full <= 1'b0;
      ld_rd   <= ZERO_REG;
      ld_data <= '0;
    end else if (accept) begin
      ld_full <= 1'b1;
      ld_rd   <= wb_ld_rd;
      ld_data <= wb_ld_data;
    end else if (drain) begin
      ld_full <= 1'b0;
    end
  end

  // Writes to x0 are consumed but never strobed into the bank.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wb_reg_wr_en   <= 1'b0;
      wb_reg_wr_addr <= ZERO_REG;
      wb_reg_in      <= '0;
    end else begin
      wb_reg_wr_en <= (sel_src != SRC_NONE) && (sel_rd != ZERO_REG);
      if (sel_src != SRC_NONE) begin
        wb_reg_wr_addr <= sel_rd;
        wb_reg_in      <= sel_data;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (wb_clk),
    .rst      (wb_rst),
    .set_en   (wb_issue_en),
    .set_addr (wb_issue_rd),
    .clr_en   (wb_reg_wr_en),
    .clr_addr (wb_reg_wr_addr),
    .chk_en   (sel_src != SRC_NONE),
    .chk_addr (sel_rd),
    .rs1_addr (wb_rs1_addr),
    .rs2_addr (wb_rs2_addr),
    .rs1_busy (wb_rs1_busy),
    .rs2_busy (wb_rs2_busy),
    .rd_busy  (wb_rd_busy),
    .err      (wb_err)
  );
endmodule
